// File: rtl/seven_seg_scan_controller.sv
// rtl/seven_seg_scan_controller.sv - four-digit seven-segment scan controller with frame-aligned double buffering
module seven_seg_scan_controller #(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank,
  input  logic        update,
  output logic [3:0]  Sel,
  output logic [3:0]  control,
  output logic        Dp,
  output logic        pending,
  output logic        frame_done
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   st_value_q, st_value_d;
  logic [3:0]    st_dp_q, st_dp_d;
  logic [3:0]    st_blank_q, st_blank_d;
  logic [15:0]   sh_value_q, sh_value_d;
  logic [3:0]    sh_dp_q, sh_dp_d;
  logic [3:0]    sh_blank_q, sh_blank_d;
  logic          pending_q, pending_d;
  logic          frame_done_q, frame_done_d;

  logic slot_end;
  logic boundary;
  logic dark;

  assign slot_end = (cnt_q == SLOT_LAST);
  assign boundary = slot_end && (idx_q == 2'd3);

  // Next-state: slot/digit counting, staging of requests, and shadow load on frame boundaries
  always_comb begin
    cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
    idx_d        = slot_end ? idx_q + 2'd1 : idx_q;
    st_value_d   = st_value_q;
    st_dp_d      = st_dp_q;
    st_blank_d   = st_blank_q;
    sh_value_d   = sh_value_q;
    sh_dp_d      = sh_dp_q;
    sh_blank_d   = sh_blank_q;
    pending_d    = pending_q;
    frame_done_d = boundary;

    if (boundary) begin
      // A request arriving on the boundary itself bypasses staging so it is not delayed a frame.
      if (update) begin
        st_value_d = value;
        st_dp_d    = dp_in;
        st_blank_d = blank;
        sh_value_d = value;
        sh_dp_d    = dp_in;
        sh_blank_d = blank;
      end else if (pending_q) begin
        sh_value_d = st_value_q;
        sh_dp_d    = st_dp_q;
        sh_blank_d = st_blank_q;
      end
      pending_d = 1'b0;
    end else if (update) begin
      st_value_d = value;
      st_dp_d    = dp_in;
      st_blank_d = blank;
      pending_d  = 1'b1;
    end
  end

  // State registers; reset leaves the display dark until the first update reaches the shadow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      st_value_q   <= 16'h0000;
      st_dp_q      <= 4'b0000;
      st_blank_q   <= 4'b0000;
      sh_value_q   <= 16'h0000;
      sh_dp_q      <= 4'b0000;
      sh_blank_q   <= 4'b1111;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      st_value_q   <= st_value_d;
      st_dp_q      <= st_dp_d;
      st_blank_q   <= st_blank_d;
      sh_value_q   <= sh_value_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Display drive from registered state only; Sel leads the anode so the decoder settles during blanking
  always_comb begin
    dark    = (cnt_q < BLANK_END) || sh_blank_q[idx_q];
    Sel     = sh_value_q[{idx_q, 2'b00} +: 4];
    control = dark ? 4'b1111 : ~(4'b0001 << idx_q);
    Dp      = dark ? 1'b1 : ~sh_dp_q[idx_q];
  end

  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule
